// File: rtl/fmul_pkg.sv
// Shared types and float-field constants for the multiplier front end.
package fmul_pkg;

  localparam int unsigned FLT_W    = 24;
  localparam int unsigned SIGN_BIT = 23;
  localparam int unsigned EXP_MSB  = 22;
  localparam int unsigned EXP_LSB  = 16;
  localparam int unsigned MAN_W    = 16;
  // Tag IDs are sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef logic [FLT_W-1:0] flt_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    gnt_id_o,
  output logic              gnt_valid_o
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(ptr_i) + k) % NumReq;
      if (en_i && !gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_id_o    = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one pipelined float multiplier among NUM_REQ requesters; a tag pipeline
// matched to the multiplier latency steers each result back to its issuer.
module fmul_arbiter
  import fmul_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned ID_W        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [FLT_W*NUM_REQ-1:0] req_a,
  input  logic [FLT_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     hold,
  output logic [FLT_W-1:0]         mul_a,
  output logic [FLT_W-1:0]         mul_b,
  input  logic [FLT_W-1:0]         mul_out,
  input  logic                     mul_ovf,
  input  logic                     mul_unf,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [FLT_W-1:0]         rsp_data,
  output logic                     rsp_ovf,
  output logic                     rsp_unf,
  output logic                     idle,
  output logic [15:0]              issue_cnt
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               issue;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  flt_t               mul_a_q, mul_b_q, a_sel, b_sel;
  tag_t               tag_q [MUL_LATENCY+1];
  tag_t               tag_in, tag_last;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  flt_t               rsp_data_q;
  logic               rsp_ovf_q, rsp_unf_q;
  logic [15:0]        issue_cnt_q;
  logic               inflight;

  rr_arbiter #(
    .NumReq(NUM_REQ),
    .IdW   (ID_W)
  ) u_rr (
    .en_i       (!rst && !hold),
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id),
    .gnt_valid_o(issue)
  );

  always_comb begin
    a_sel        = req_a[32'(gnt_id)*FLT_W +: FLT_W];
    b_sel        = req_b[32'(gnt_id)*FLT_W +: FLT_W];
    tag_in.valid = issue;
    tag_in.id    = TAG_ID_W'(gnt_id);
    tag_last     = tag_q[MUL_LATENCY];
    rr_ptr_d     = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    inflight = 1'b0;
    for (int i = 0; i <= int'(MUL_LATENCY); i++) begin
      inflight = inflight | tag_q[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rr_ptr_q    <= '0;
      issue_cnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
      for (int i = 0; i <= int'(MUL_LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (issue) begin
        mul_a_q     <= a_sel;
        mul_b_q     <= b_sel;
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i <= int'(MUL_LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      // Final tag stage lines up with mul_out; the result is captured one edge later.
      if (tag_last.valid) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_last.id;
        rsp_id_q    <= ID_W'(tag_last.id);
        rsp_data_q  <= mul_out;
        rsp_ovf_q   <= mul_ovf;
        rsp_unf_q   <= mul_unf;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign req_ready = gnt;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_unf   = rsp_unf_q;
  assign idle      = !inflight && !issue;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
Round-robin scheduler that shares the single pipelined 24-bit float multiplier (sign[23], exp[22:16], mantissa[15:0]) between NUM_REQ requesters.
- Accepts operand pairs over a valid/ready handshake and registers the winner's operands onto the multiplier inputs.
- Tracks each issued operation's requester ID through a tag pipeline matched to the multiplier latency.
- Routes each result, with its overflow/underflow flags, back to the issuing requester.
- Sits between the requesting compute units and the multiplier top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MUL_LATENCY, 3, clocks from a stable value on mul_a/mul_b to the matching value on mul_out/mul_ovf/mul_unf
ID_W, 2, requester index width; must equal clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand-pair valid
req_a  in  24*NUM_REQ  operand A, requester i at [24*i+23:24*i]
req_b  in  24*NUM_REQ  operand B, same packing
req_ready  out  NUM_REQ  one-hot grant, combinational
hold  in  1  stop issuing new operations; in-flight operations still drain
mul_a  out  24  registered operand A to the multiplier
mul_b  out  24  registered operand B to the multiplier
mul_out  in  24  multiplier result
mul_ovf  in  1  multiplier overflow flag
mul_unf  in  1  multiplier underflow flag
rsp_valid  out  NUM_REQ  one-hot result strobe, single cycle, no backpressure
rsp_id  out  ID_W  index of the requester receiving the result
rsp_data  out  24  result
rsp_ovf  out  1  result overflow flag
rsp_unf  out  1  result underflow flag
idle  out  1  high when no operation is in flight and no issue is occurring this cycle
issue_cnt  out  16  count of issued operations, wraps 0xFFFF->0

Behaviour:
- Reset values: rst=1 at a clock edge clears mul_a/mul_b, rsp_*, issue_cnt, rr_ptr and all tag-valid bits. req_ready is 0 while rst=1; idle is 1 on the first cycle after reset.
- Arbitration: combinational. The winner is the first i with req_valid[i]=1, searching i=rr_ptr, rr_ptr+1, … modulo NUM_REQ. req_ready asserts only for the winner; all bits are 0 if hold=1 or no request is valid.
- req_ready depends on req_valid, which is allowed. Requesters must not make req_valid depend on req_ready.
- Issue: occurs when req_valid[w] && req_ready[w]. At that clock edge:
  - mul_a/mul_b <= req_a/req_b slice of w;
  - rr_ptr <= (w+1) mod NUM_REQ;
  - issue_cnt += 1;
  - tag stage 0 <= {valid=1, id=w}.
- No issue: mul_a/mul_b hold their value, rr_ptr holds, and tag stage 0 is loaded with valid=0.
- Throughput: one issue per clock maximum. Back-to-back issues from different requesters are legal every cycle.
- Tag pipeline: MUL_LATENCY+1 stages of {valid, id}, shifting every cycle unconditionally. The multiplier never stalls.
- Final tag stage aligns with mul_out. When the final stage is valid, at the next edge:
  - rsp_valid <= onehot(id);
  - rsp_id <= id;
  - rsp_data/ovf/unf <= mul_out/ovf/unf.
  Otherwise rsp_valid <= 0, and rsp_id/rsp_data/rsp_ovf/rsp_unf hold.
- Latency: the handshake edge at cycle t produces rsp_valid high during cycle t+MUL_LATENCY+2 (5 at defaults).
- Ordering: results return in issue order. Per-requester order is preserved.
- hold: takes effect the same cycle (combinational gating of req_ready). Operations already in flight complete normally.
- idle = no tag stage valid AND no issue this cycle.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is generated for them, even though the multiplier may still emit stale data.
- Simultaneous issue and response in the same cycle: independent, both occur.

Decomposition:
- Package fmul_pkg holds:
  - constants FLT_W=24, EXP_MSB=22, EXP_LSB=16, MAN_W=16, SIGN_BIT=23;
  - typedef flt_t (24-bit);
  - typedef tag_t {valid, id}.
- One sub-module, rr_arbiter: combinational NUM_REQ-way round-robin grant from req vector + pointer.

Test Plan:
Bench stub multiplier: mul_out = mul_a ^ mul_b, flags = mul_a[0]/mul_b[0], delayed MUL_LATENCY.
1. Single request: at t, req_valid=0001, a=0x3F8000, b=0x400000 -> req_ready=0001 at t; rsp_valid=0001, rsp_data=0x7F8000, rsp_id=0 at t+5; issue_cnt=1.
2. All four valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; rsp_id follows the same order 5 cycles later with no gaps.
3. Requesters 1 and 3 valid, rr_ptr=2 -> grant 3, then 1, then 3.
4. hold=1 while 2 operations are in flight -> req_ready=0; both responses still arrive; idle=1 one cycle after the last tag leaves the final stage (rsp_valid high on that cycle).
5. rst pulsed 2 cycles after issue -> no rsp_valid for that operation; issue_cnt=0; next grant goes to requester 0.
6. Preload issue_cnt=0xFFFF via 65535 issues, then 1 more -> issue_cnt=0x0000.
